// File: rtl/banked_register_file.sv
// -----------------------------------------------------------------------------
// banked_register_file
//   ARM-style register file. Provides NUM_RD combinational read ports and two
//   write ports (A = ALU result, B = load result) with optional write-to-read
//   bypass. r13/r14 are banked per mode, r8-r12 optionally banked for FIQ.
//   r15 is a dedicated PC register: reset vector, sequential update, and
//   reads return PC + PC_OFFSET.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   mode         current mode (0 USR, 1 FIQ, 2 IRQ, 3 SVC) for reads and writes
//   ra           read addresses, port k at [4k+3:4k]
//   rd           read data, port k at [DATA_W*k +: DATA_W]
//   wea/waa/wda  write port A enable / address / data
//   web/wab/wdb  write port B enable / address / data (wins over A)
//   pc_we        sequential PC update enable
//   pc_next      sequential PC value
//   pc           current PC register
//   wr_conflict  registered: previous edge had A and B writing the same register
// -----------------------------------------------------------------------------
module banked_register_file #(
  parameter int                DATA_W    = 32,
  parameter int                NUM_RD    = 3,
  parameter int                PC_OFFSET = 8,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter int                FIQ_BANK  = 1,
  parameter int                BYPASS    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic [4*NUM_RD-1:0]      ra,
  output logic [DATA_W*NUM_RD-1:0] rd,
  input  logic                     wea,
  input  logic [3:0]               waa,
  input  logic [DATA_W-1:0]        wda,
  input  logic                     web,
  input  logic [3:0]               wab,
  input  logic [DATA_W-1:0]        wdb,
  input  logic                     pc_we,
  input  logic [DATA_W-1:0]        pc_next,
  output logic [DATA_W-1:0]        pc,
  output logic                     wr_conflict
);

  // Physical layout: [0..7] r0-r7, [8..12] user r8-r12, [13..17] FIQ r8-r12
  // (only with FIQ_BANK), then one r13/r14 pair per mode.
  localparam int NUM_HI_SETS = (FIQ_BANK != 0) ? 2 : 1;
  localparam int BANK_BASE   = 8 + 5 * NUM_HI_SETS;
  localparam int NUM_GPR     = BANK_BASE + 8;
  localparam int PIDX_W      = $clog2(NUM_GPR);

  localparam logic [DATA_W-1:0] PC_OFS = DATA_W'(PC_OFFSET);
  localparam logic BYPASS_EN = (BYPASS != 0);

  function automatic logic [PIDX_W-1:0] phys_idx(input logic [1:0] m,
                                                  input logic [3:0] a);
    int idx;
    if (a < 4'd8) begin
      idx = int'(a);
    end else if (a < 4'd13) begin
      idx = (FIQ_BANK != 0 && m == 2'd1) ? int'(a) + 5 : int'(a);
    end else begin
      // a == 15 never reaches storage; it maps onto r13 to stay in range
      idx = BANK_BASE + 2 * int'(m) + ((a == 4'd14) ? 1 : 0);
    end
    return PIDX_W'(idx);
  endfunction

  logic [DATA_W-1:0] regs_q [NUM_GPR];
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              wr_conflict_q, wr_conflict_d;

  logic [PIDX_W-1:0] pidx_a, pidx_b;
  logic              wa_gpr, wb_gpr;
  logic              bypass_on;
  logic [NUM_GPR-1:0] wr_en;
  logic [DATA_W-1:0]  wr_data [NUM_GPR];

  assign pidx_a = phys_idx(mode, waa);
  assign pidx_b = phys_idx(mode, wab);
  assign wa_gpr = wea && (waa != 4'hF);
  assign wb_gpr = web && (wab != 4'hF);

  // Bypass is suppressed while reset is held so rd shows the cleared state.
  assign bypass_on = BYPASS_EN && rst_n;

  // Per-register write select; port B overrides port A on the same register.
  generate
    for (genvar gi = 0; gi < NUM_GPR; gi++) begin : g_wsel
      logic sel_a, sel_b;
      assign sel_a       = wa_gpr && (pidx_a == PIDX_W'(gi));
      assign sel_b       = wb_gpr && (pidx_b == PIDX_W'(gi));
      assign wr_en[gi]   = sel_a | sel_b;
      assign wr_data[gi] = sel_b ? wdb : wda;
    end
  endgenerate

  always_comb begin
    pc_d = pc_q;
    if (web && wab == 4'hF)      pc_d = wdb;
    else if (wea && waa == 4'hF) pc_d = wda;
    else if (pc_we)              pc_d = pc_next;
  end

  // Same logical address in the same cycle always means same physical register.
  assign wr_conflict_d = wea && web && (waa == wab);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GPR; i++) regs_q[i] <= '0;
      pc_q          <= RESET_PC;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (wr_en[i]) regs_q[i] <= wr_data[i];
      end
      pc_q          <= pc_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign pc          = pc_q;
  assign wr_conflict = wr_conflict_q;

  // Read ports. Bank selection is shared by reads and writes, so an address
  // match between a read and a write in the same cycle is a physical match.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [3:0]        addr;
      logic [DATA_W-1:0] val;
      assign addr = ra[4*gi +: 4];
      always_comb begin
        val = regs_q[phys_idx(mode, addr)];
        if (addr == 4'hF)                            val = (bypass_on ? pc_d : pc_q) + PC_OFS;
        else if (bypass_on && web && wab == addr)    val = wdb;
        else if (bypass_on && wea && waa == addr)    val = wda;
      end
      assign rd[DATA_W*gi +: DATA_W] = val;
    end
  endgenerate

endmodule

// File: tb/tb_banked_register_file.sv
module tb_banked_register_file;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [11:0] ra;
  logic [95:0] rd, rd_nb;
  logic        wea, web, pc_we;
  logic [3:0]  waa, wab;
  logic [31:0] wda, wdb, pc_next;
  logic [31:0] pc, pc_nb;
  logic        wr_conflict, wrc_nb;

  banked_register_file #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ra(ra), .rd(rd),
    .wea(wea), .waa(waa), .wda(wda), .web(web), .wab(wab), .wdb(wdb),
    .pc_we(pc_we), .pc_next(pc_next), .pc(pc), .wr_conflict(wr_conflict)
  );

  banked_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ra(ra), .rd(rd_nb),
    .wea(wea), .waa(waa), .wda(wda), .web(web), .wab(wab), .wdb(wdb),
    .pc_we(pc_we), .pc_next(pc_next), .pc(pc_nb), .wr_conflict(wrc_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: expectations queued while driving, popped at the sample point.
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam int S_RD0 = 0, S_RD1 = 1, S_RD2 = 2, S_PC = 3, S_WRC = 4,
                 S_NB_RD0 = 5, S_NB_PC = 6, S_NB_WRC = 7;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RD0:    return rd[31:0];
      S_RD1:    return rd[63:32];
      S_RD2:    return rd[95:64];
      S_PC:     return pc;
      S_WRC:    return {31'b0, wr_conflict};
      S_NB_RD0: return rd_nb[31:0];
      S_NB_PC:  return pc_nb;
      S_NB_WRC: return {31'b0, wrc_nb};
      default:  return 'x;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sel);
      tests_run++;
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
      $display("[TB] %s observed %h", e.tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int port, input logic [3:0] a);
    ra[4*port +: 4] = a;
  endtask

  task automatic do_write(input logic [1:0] m, input logic port_b,
                          input logic [3:0] a, input logic [31:0] d);
    mode = m;
    if (port_b) begin web = 1'b1; wab = a; wdb = d; end
    else        begin wea = 1'b1; waa = a; wda = d; end
    $display("[TB] write mode=%0d port=%s r%0d=%h", m, port_b ? "B" : "A", a, d);
    step();
    wea = 1'b0;
    web = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; mode = 2'd0; ra = '0;
    wea = 1'b0; web = 1'b0; pc_we = 1'b0;
    waa = '0; wab = '0; wda = '0; wdb = '0; pc_next = '0;
    #2 rst_n = 1'b0;
    step();

    // ---- reset state: all 16 addresses in USR ----
    for (int a = 0; a < 16; a++) begin
      set_ra(0, 4'(a));
      expect_v($sformatf("reset_r%0d", a), S_RD0, (a == 15) ? 32'h8 : 32'h0);
      check();
    end
    expect_v("reset_pc", S_PC, 32'h0);
    expect_v("reset_wrc", S_WRC, 32'h0);
    check();

    step();
    rst_n = 1'b1;
    step();

    // ---- sequential PC update; r15 bypass with pc_we only ----
    set_ra(0, 4'hF);
    pc_we = 1'b1; pc_next = 32'h4;
    expect_v("pc_we_bypass", S_RD0, 32'hC);
    expect_v("pc_we_nobypass", S_NB_RD0, 32'h8);
    check();
    step();
    pc_we = 1'b0;
    expect_v("pc_after_we_r15", S_RD0, 32'hC);
    expect_v("pc_after_we", S_PC, 32'h4);
    check();

    // ---- banking ----
    do_write(2'd0, 1'b0, 4'd13, 32'h1111);
    do_write(2'd3, 1'b1, 4'd13, 32'h2222);
    do_write(2'd0, 1'b0, 4'd8,  32'hAA);
    do_write(2'd1, 1'b1, 4'd8,  32'hBB);
    set_ra(0, 4'd13); set_ra(1, 4'd8); set_ra(2, 4'd14);
    mode = 2'd0;
    expect_v("usr_r13", S_RD0, 32'h1111);
    expect_v("usr_r8",  S_RD1, 32'hAA);
    expect_v("usr_r14", S_RD2, 32'h0);
    check();
    mode = 2'd3;
    expect_v("svc_r13", S_RD0, 32'h2222);
    expect_v("svc_r8",  S_RD1, 32'hAA);
    check();
    mode = 2'd1;
    expect_v("fiq_r13", S_RD0, 32'h0);
    expect_v("fiq_r8",  S_RD1, 32'hBB);
    check();
    mode = 2'd2;
    expect_v("irq_r13", S_RD0, 32'h0);
    expect_v("irq_r8",  S_RD1, 32'hAA);
    check();

    // ---- dual-write conflict, repeated on two edges ----
    mode = 2'd0;
    set_ra(0, 4'd3); set_ra(1, 4'd4);
    wea = 1'b1; waa = 4'd3; wda = 32'h5;
    web = 1'b1; wab = 4'd3; wdb = 32'h9;
    expect_v("conf_bypass_b", S_RD0, 32'h9);
    expect_v("conf_nobypass", S_NB_RD0, 32'h0);
    check();
    step();
    expect_v("conf_wrc_1", S_WRC, 32'h1);
    check();
    step();
    wea = 1'b0; web = 1'b0;
    expect_v("conf_wrc_repeat", S_WRC, 32'h1);
    expect_v("conf_wrc_repeat_nb", S_NB_WRC, 32'h1);
    check();
    step();
    expect_v("conf_wrc_clear", S_WRC, 32'h0);
    expect_v("conf_r3", S_RD0, 32'h9);
    check();
    wea = 1'b1; waa = 4'd4; wda = 32'h5;
    web = 1'b1; wab = 4'd3; wdb = 32'h19;
    step();
    wea = 1'b0; web = 1'b0;
    expect_v("dual_r3", S_RD0, 32'h19);
    expect_v("dual_r4", S_RD1, 32'h5);
    expect_v("dual_wrc", S_WRC, 32'h0);
    check();

    // ---- PC priority ----
    set_ra(0, 4'hF);
    pc_we = 1'b1; pc_next = 32'h100;
    wea = 1'b1; waa = 4'hF; wda = 32'h400;
    expect_v("pcpri_a_bypass", S_RD0, 32'h408);
    expect_v("pcpri_a_nobypass", S_NB_RD0, 32'hC);
    check();
    step();
    expect_v("pcpri_a", S_PC, 32'h400);
    check();
    web = 1'b1; wab = 4'hF; wdb = 32'h800;
    expect_v("pcpri_b_bypass", S_RD0, 32'h808);
    check();
    step();
    wea = 1'b0; web = 1'b0;
    expect_v("pcpri_b", S_PC, 32'h800);
    expect_v("pcpri_wrc", S_WRC, 32'h1);
    expect_v("pcpri_next_bypass", S_RD0, 32'h108);
    check();
    step();
    pc_we = 1'b0;
    expect_v("pcpri_next", S_PC, 32'h100);
    expect_v("pcpri_wrc_clear", S_WRC, 32'h0);
    check();
    do_write(2'd0, 1'b1, 4'hF, 32'hFFFF_FFFC);
    expect_v("pc_wrap_r15", S_RD0, 32'h4);
    expect_v("pc_wrap_pc", S_PC, 32'hFFFF_FFFC);
    expect_v("pc_wrap_pc_nb", S_NB_PC, 32'hFFFF_FFFC);
    check();

    // ---- bypass vs no bypass ----
    set_ra(0, 4'd5);
    wea = 1'b1; waa = 4'd5; wda = 32'hDEAD;
    expect_v("byp_same_cycle", S_RD0, 32'hDEAD);
    expect_v("nobyp_same_cycle", S_NB_RD0, 32'h0);
    check();
    step();
    wea = 1'b0;
    expect_v("byp_after", S_RD0, 32'hDEAD);
    expect_v("nobyp_after", S_NB_RD0, 32'hDEAD);
    check();

    // ---- asynchronous reset between edges ----
    #2;
    rst_n = 1'b0;
    set_ra(0, 4'd5); set_ra(1, 4'd3); set_ra(2, 4'hF);
    expect_v("arst_r5", S_RD0, 32'h0);
    expect_v("arst_r3", S_RD1, 32'h0);
    expect_v("arst_r15", S_RD2, 32'h8);
    expect_v("arst_pc", S_PC, 32'h0);
    expect_v("arst_r5_nb", S_NB_RD0, 32'h0);
    check();
    set_ra(0, 4'd7);
    wea = 1'b1; waa = 4'd7; wda = 32'h77;
    step();
    expect_v("arst_write_blocked", S_RD0, 32'h0);
    check();
    wea = 1'b0;
    rst_n = 1'b1;
    step();
    set_ra(0, 4'd6); set_ra(1, 4'd7);
    do_write(2'd0, 1'b0, 4'd6, 32'h66);
    expect_v("post_rst_r6", S_RD0, 32'h66);
    expect_v("post_rst_r7", S_RD1, 32'h0);
    check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
